// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared types and constants for the pipeline controller.
// Holds the FSM state enum, default mult/div timeout and the NOP encoding.
package pipeline_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    localparam int MD_TIMEOUT_DEF = 40;

    // addi x0, x0, 0 -- loaded by the latch muxes when a flush is requested
    localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use compare between F/D sources and D/X dest.
// Ports: fd_rs/fd_rt/fd_uses_* (F/D reads), dx_rd/dx_is_load (D/X), stall (out).
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0] fd_rs,
    input  logic [4:0] fd_rt,
    input  logic       fd_uses_rs,
    input  logic       fd_uses_rt,
    input  logic [4:0] dx_rd,
    input  logic       dx_is_load,
    output logic       stall
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = fd_uses_rs && (fd_rs == dx_rd);
    assign rt_hit = fd_uses_rt && (fd_rt == dx_rd);

    // r0 is hardwired to zero, so a load into it never creates a dependency
    assign stall = dx_is_load && (dx_rd != 5'd0) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard/sequencing controller for the five-stage pipeline.
// Inputs: F/D sources, D/X dest/kind, branch, md_ready. Outputs: latch enables,
// flush/bubble, mult/div handshake (start/busy/timeout/error), stall_count.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MD_TIMEOUT = MD_TIMEOUT_DEF,
    parameter int CNT_W      = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  fd_rs,
    input  logic [4:0]  fd_rt,
    input  logic        fd_uses_rs,
    input  logic        fd_uses_rt,
    input  logic [4:0]  dx_rd,
    input  logic        dx_is_load,
    input  logic        dx_is_multdiv,
    input  logic        x_branch_taken,
    input  logic        md_ready,
    output logic        pc_wren,
    output logic        fd_wren,
    output logic        dx_wren,
    output logic        xm_wren,
    output logic        mw_wren,
    output logic        fd_flush,
    output logic        dx_flush,
    output logic        xm_bubble,
    output logic        md_start,
    output logic        md_busy,
    output logic        md_timeout,
    output logic        md_error,
    output logic [31:0] stall_count
);

    state_t           state;
    logic [CNT_W-1:0] md_cnt;
    logic             load_use;
    logic             go_wait;
    logic             go_run;
    logic             md_last;

    hazard_detect u_hazard (
        .fd_rs      (fd_rs),
        .fd_rt      (fd_rt),
        .fd_uses_rs (fd_uses_rs),
        .fd_uses_rt (fd_uses_rt),
        .dx_rd      (dx_rd),
        .dx_is_load (dx_is_load),
        .stall      (load_use)
    );

    assign md_last = (md_cnt == CNT_W'(MD_TIMEOUT - 1));

    always_comb begin
        pc_wren    = 1'b1;
        fd_wren    = 1'b1;
        dx_wren    = 1'b1;
        xm_wren    = 1'b1;
        mw_wren    = 1'b1;
        fd_flush   = 1'b0;
        dx_flush   = 1'b0;
        xm_bubble  = 1'b0;
        md_start   = 1'b0;
        md_busy    = 1'b0;
        md_timeout = 1'b0;
        go_wait    = 1'b0;
        go_run     = 1'b0;
        if (!reset) begin
            unique case (state)
                RUN: begin
                    if (dx_is_multdiv) begin
                        md_start  = 1'b1;
                        pc_wren   = 1'b0;
                        fd_wren   = 1'b0;
                        dx_wren   = 1'b0;
                        xm_bubble = 1'b1;
                        go_wait   = 1'b1;
                    end else if (x_branch_taken) begin
                        fd_flush = 1'b1;
                        dx_flush = 1'b1;
                    end else if (load_use) begin
                        pc_wren  = 1'b0;
                        fd_wren  = 1'b0;
                        dx_flush = 1'b1;
                    end
                end
                MD_WAIT: begin
                    md_busy = 1'b1;
                    if (md_ready) begin
                        go_run = 1'b1;
                    end else if (md_last) begin
                        md_timeout = 1'b1;
                        go_run     = 1'b1;
                    end else begin
                        pc_wren   = 1'b0;
                        fd_wren   = 1'b0;
                        dx_wren   = 1'b0;
                        xm_bubble = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= RUN;
            md_cnt      <= '0;
            md_error    <= 1'b0;
            stall_count <= '0;
        end else begin
            if (go_wait) begin
                state  <= MD_WAIT;
                md_cnt <= '0;
            end else if (go_run) begin
                state <= RUN;
            end else if (state == MD_WAIT) begin
                md_cnt <= md_cnt + 1'b1;
            end
            if (md_timeout) begin
                md_error <= 1'b1;
            end
            if (!pc_wren && (stall_count != '1)) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: scoreboard bench for pipeline_ctrl.
// Expected outputs are pushed per driven cycle and popped at the negedge.
module tb_pipeline_ctrl;

    localparam int TMO = 40;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  fd_rs = '0;
    logic [4:0]  fd_rt = '0;
    logic        fd_uses_rs = 1'b0;
    logic        fd_uses_rt = 1'b0;
    logic [4:0]  dx_rd = '0;
    logic        dx_is_load = 1'b0;
    logic        dx_is_multdiv = 1'b0;
    logic        x_branch_taken = 1'b0;
    logic        md_ready = 1'b0;
    logic        pc_wren, fd_wren, dx_wren, xm_wren, mw_wren;
    logic        fd_flush, dx_flush, xm_bubble;
    logic        md_start, md_busy, md_timeout, md_error;
    logic [31:0] stall_count;

    pipeline_ctrl #(.MD_TIMEOUT(TMO), .CNT_W(6)) dut (
        .clock          (clock),
        .reset          (reset),
        .fd_rs          (fd_rs),
        .fd_rt          (fd_rt),
        .fd_uses_rs     (fd_uses_rs),
        .fd_uses_rt     (fd_uses_rt),
        .dx_rd          (dx_rd),
        .dx_is_load     (dx_is_load),
        .dx_is_multdiv  (dx_is_multdiv),
        .x_branch_taken (x_branch_taken),
        .md_ready       (md_ready),
        .pc_wren        (pc_wren),
        .fd_wren        (fd_wren),
        .dx_wren        (dx_wren),
        .xm_wren        (xm_wren),
        .mw_wren        (mw_wren),
        .fd_flush       (fd_flush),
        .dx_flush       (dx_flush),
        .xm_bubble      (xm_bubble),
        .md_start       (md_start),
        .md_busy        (md_busy),
        .md_timeout     (md_timeout),
        .md_error       (md_error),
        .stall_count    (stall_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [10:0] ctl;
        logic        err;
        logic [31:0] stalls;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // bench-side reference state; wait cycles numbered from 1
    logic        m_wait = 1'b0;
    int          m_wc = 0;
    logic        m_err = 1'b0;
    logic [31:0] m_stall = '0;
    logic        n_wait;
    int          n_wc;
    logic        n_err;
    logic [31:0] n_stall;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t predict();
        exp_t e;
        logic [4:0] w;
        logic ff, df, xb, ms, mb, mt, lu;
        lu = dx_is_load && dx_rd != 5'd0 &&
             ((fd_uses_rs && fd_rs == dx_rd) || (fd_uses_rt && fd_rt == dx_rd));
        w = 5'b11111;
        {ff, df, xb, ms, mb, mt} = '0;
        n_wait = m_wait;
        n_wc = m_wc;
        n_err = m_err;
        if (reset) begin
            n_wait = 1'b0;
            n_wc = 0;
            n_err = 1'b0;
        end else if (m_wait) begin
            mb = 1'b1;
            if (md_ready) begin
                n_wait = 1'b0;
            end else if (m_wc == TMO) begin
                mt = 1'b1;
                n_err = 1'b1;
                n_wait = 1'b0;
            end else begin
                w = 5'b00011;
                xb = 1'b1;
                n_wc = m_wc + 1;
            end
        end else if (dx_is_multdiv) begin
            ms = 1'b1;
            w = 5'b00011;
            xb = 1'b1;
            n_wait = 1'b1;
            n_wc = 1;
        end else if (x_branch_taken) begin
            ff = 1'b1;
            df = 1'b1;
        end else if (lu) begin
            w = 5'b00111;
            df = 1'b1;
        end
        if (reset) n_stall = '0;
        else if (!w[4] && m_stall != 32'hFFFF_FFFF) n_stall = m_stall + 1;
        else n_stall = m_stall;
        e.ctl = {w, ff, df, xb, ms, mb, mt};
        e.err = m_err;
        e.stalls = m_stall;
        return e;
    endfunction

    task automatic cycle();
        exp_t e;
        logic [10:0] got;
        sb.push_back(predict());
        @(negedge clock);
        e = sb.pop_front();
        got = {pc_wren, fd_wren, dx_wren, xm_wren, mw_wren, fd_flush,
               dx_flush, xm_bubble, md_start, md_busy, md_timeout};
        check("ctl", {21'd0, got}, {21'd0, e.ctl});
        check("md_error", {31'd0, md_error}, {31'd0, e.err});
        check("stall_count", stall_count, e.stalls);
        @(posedge clock);
        m_wait = n_wait;
        m_wc = n_wc;
        m_err = n_err;
        m_stall = n_stall;
        #1;
    endtask

    task automatic idle();
        {fd_uses_rs, fd_uses_rt, dx_is_load, dx_is_multdiv} = '0;
        {x_branch_taken, md_ready, reset} = '0;
        fd_rs = '0;
        fd_rt = '0;
        dx_rd = '0;
    endtask

    logic [31:0] base;

    initial begin
        @(posedge clock);
        #1;
        cycle();
        cycle();
        idle();
        cycle();

        // load-use on rs, then r0 load, then rt / unused-source cases
        base = m_stall;
        dx_is_load = 1'b1; dx_rd = 5'd5; fd_uses_rs = 1'b1; fd_rs = 5'd5;
        cycle();
        idle();
        cycle();
        check("lu_one_stall", stall_count - base, 32'd1);
        dx_is_load = 1'b1; dx_rd = 5'd0; fd_uses_rs = 1'b1; fd_rs = 5'd0;
        cycle();
        dx_rd = 5'd9; fd_uses_rs = 1'b0; fd_rs = 5'd9; fd_uses_rt = 1'b1; fd_rt = 5'd9;
        cycle();
        fd_uses_rt = 1'b0;
        cycle();
        idle();

        // taken branch, then md_ready in RUN
        base = m_stall;
        x_branch_taken = 1'b1;
        cycle();
        idle();
        md_ready = 1'b1;
        cycle();
        idle();
        check("br_no_stall", stall_count - base, 32'd0);

        // multdiv beats branch; hazards ignored while waiting; ready at md_cnt 17
        base = m_stall;
        dx_is_multdiv = 1'b1; x_branch_taken = 1'b1;
        cycle();
        x_branch_taken = 1'b1; dx_is_load = 1'b1; dx_rd = 5'd3;
        fd_uses_rs = 1'b1; fd_rs = 5'd3;
        for (int i = 1; i <= 17; i++) cycle();
        md_ready = 1'b1;
        cycle();
        idle();
        cycle();
        check("md_frozen18", stall_count - base, 32'd18);

        // back-to-back multdiv, ready on third wait cycle each time
        for (int k = 0; k < 2; k++) begin
            dx_is_multdiv = 1'b1;
            cycle();
            for (int i = 1; i <= 2; i++) cycle();
            md_ready = 1'b1;
            cycle();
            md_ready = 1'b0;
        end
        idle();
        cycle();

        // timeout: never ready
        dx_is_multdiv = 1'b1;
        cycle();
        dx_is_multdiv = 1'b0;
        for (int i = 1; i <= TMO; i++) cycle();
        cycle();
        check("err_sticky", {31'd0, md_error}, 32'd1);
        for (int i = 0; i < 3; i++) cycle();

        // reset during wait cycle 10
        dx_is_multdiv = 1'b1;
        cycle();
        dx_is_multdiv = 1'b0;
        for (int i = 1; i <= 9; i++) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();
        check("rst_busy", {31'd0, md_busy}, 32'd0);
        check("rst_err", {31'd0, md_error}, 32'd0);

        // random traffic against the reference
        for (int i = 0; i < 400; i++) begin
            fd_rs = 5'($urandom_range(0, 3));
            fd_rt = 5'($urandom_range(0, 3));
            dx_rd = 5'($urandom_range(0, 3));
            fd_uses_rs = 1'($urandom_range(0, 1));
            fd_uses_rt = 1'($urandom_range(0, 1));
            dx_is_load = 1'($urandom_range(0, 1));
            dx_is_multdiv = ($urandom_range(0, 9) == 0);
            x_branch_taken = ($urandom_range(0, 4) == 0);
            md_ready = ($urandom_range(0, 15) == 0);
            reset = ($urandom_range(0, 199) == 0);
            cycle();
        end
        idle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
